nes_multi_timer: RTL and testbench

//  Parametrised N-channel interval timer; Avalon-MM slave on the NES SoC system bus.

---
 rtl/nes_timer_pkg.sv | 24 ++
 rtl/nes_timer_channel.sv | 127 ++++++++++++
 rtl/nes_multi_timer.sv | 78 +++++++
 tb/tb_nes_multi_timer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/nes_timer_pkg.sv
// Shared register map and bit positions for the NES multi-channel interval timer.
package nes_timer_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CTRL_W = 4;

  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD_L = 3'd2;
  localparam logic [2:0] REG_PERIOD_H = 3'd3;
  localparam logic [2:0] REG_SNAP_L   = 3'd4;
  localparam logic [2:0] REG_SNAP_H   = 3'd5;
  localparam logic [2:0] REG_PRESCALE = 3'd6;
  localparam logic [2:0] REG_PENDING  = 3'd7;

  localparam int unsigned CTRL_ITO   = 0;
  localparam int unsigned CTRL_CONT  = 1;
  localparam int unsigned CTRL_START = 2;
  localparam int unsigned CTRL_STOP  = 3;

  localparam int unsigned STAT_TO  = 0;
  localparam int unsigned STAT_RUN = 1;

endpackage

// File: rtl/nes_timer_channel.sv
// One timer channel: prescaler, down-counter, period/snapshot/control registers.
// Register writes arrive pre-decoded; read data is combinational for the top's mux.
module nes_timer_channel
  import nes_timer_pkg::*;
#(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned PRESCALE_W   = 8,
  parameter logic [31:0] RESET_PERIOD = 32'h1869F
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_wr,
  input  logic [2:0]        i_reg,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata_c,
  output logic              o_irq_c
);

  localparam int unsigned HI_W = CNT_W - 16;

  logic                  r_run;
  logic                  r_to;
  logic                  r_force;
  logic [CTRL_W-1:0]     r_ctrl;
  logic [CNT_W-1:0]      r_period;
  logic [CNT_W-1:0]      r_counter;
  logic [CNT_W-1:0]      r_snap;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] r_pcnt;

  logic w_tick;
  logic w_timeout;
  logic w_wr_ctrl;
  logic w_start;
  logic w_stop;
  logic w_wr_period;

  // A pending forced reload owns the counter for that cycle, so no tick is taken.
  assign w_tick      = r_run && !r_force && (r_pcnt == '0);
  assign w_timeout   = w_tick && (r_counter == '0);
  assign w_wr_ctrl   = i_wr && (i_reg == REG_CONTROL);
  assign w_start     = w_wr_ctrl && i_wdata[CTRL_START];
  assign w_stop      = w_wr_ctrl && i_wdata[CTRL_STOP];
  assign w_wr_period = i_wr && ((i_reg == REG_PERIOD_L) || (i_reg == REG_PERIOD_H));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pcnt <= '0;
    end else if (r_force || !r_run || (r_pcnt == '0)) begin
      r_pcnt <= r_prescale;
    end else begin
      r_pcnt <= r_pcnt - PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_counter <= CNT_W'(RESET_PERIOD);
    end else if (r_force) begin
      r_counter <= r_period;
    end else if (w_tick) begin
      r_counter <= w_timeout ? r_period : (r_counter - CNT_W'(1));
    end
  end

  // START beats STOP, forced reload and one-shot expiry; a timeout beats a TO clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_run   <= 1'b0;
      r_to    <= 1'b0;
      r_force <= 1'b0;
      r_ctrl  <= '0;
    end else begin
      r_force <= w_wr_period;
      if (w_wr_ctrl) begin
        r_ctrl <= i_wdata[CTRL_W-1:0];
      end
      if (w_timeout) begin
        r_to <= 1'b1;
      end else if (i_wr && (i_reg == REG_STATUS)) begin
        r_to <= 1'b0;
      end
      if (w_start) begin
        r_run <= 1'b1;
      end else if (w_stop || r_force || (w_timeout && !r_ctrl[CTRL_CONT])) begin
        r_run <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_period   <= CNT_W'(RESET_PERIOD);
      r_prescale <= '0;
      r_snap     <= '0;
    end else if (i_wr) begin
      case (i_reg)
        REG_PERIOD_L: r_period[15:0]      <= i_wdata;
        REG_PERIOD_H: r_period[CNT_W-1:16] <= HI_W'(i_wdata);
        REG_SNAP_L,
        REG_SNAP_H:   r_snap              <= r_counter;
        REG_PRESCALE: r_prescale          <= PRESCALE_W'(i_wdata);
        default: ;
      endcase
    end
  end

  always_comb begin
    o_rdata_c = '0;
    case (i_reg)
      REG_STATUS: begin
        o_rdata_c[STAT_TO]  = r_to;
        o_rdata_c[STAT_RUN] = r_run;
      end
      REG_CONTROL:  o_rdata_c = DATA_W'(r_ctrl);
      REG_PERIOD_L: o_rdata_c = r_period[15:0];
      REG_PERIOD_H: o_rdata_c = DATA_W'(r_period[CNT_W-1:16]);
      REG_SNAP_L:   o_rdata_c = r_snap[15:0];
      REG_SNAP_H:   o_rdata_c = DATA_W'(r_snap[CNT_W-1:16]);
      REG_PRESCALE: o_rdata_c = DATA_W'(r_prescale);
      default:      o_rdata_c = '0;
    endcase
  end

  assign o_irq_c = r_to && r_ctrl[CTRL_ITO];

endmodule

// File: rtl/nes_multi_timer.sv
// N-channel interval timer, Avalon-MM slave: address decode, per-channel write
// strobes, registered read mux and combined interrupt.
module nes_multi_timer
  import nes_timer_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned PRESCALE_W   = 8,
  parameter logic [31:0] RESET_PERIOD = 32'h1869F
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [$clog2(NUM_CH)+2:0]  address,
  input  logic                       chipselect,
  input  logic                       write_n,
  input  logic [15:0]                writedata,
  output logic [15:0]                readdata,
  output logic                       irq,
  output logic [NUM_CH-1:0]          irq_vec
);

  logic [7:0]        w_ch;
  logic [2:0]        w_reg;
  logic              w_ch_ok;
  logic              w_wr;
  logic [DATA_W-1:0] w_ch_rdata [NUM_CH];
  logic [DATA_W-1:0] w_rd_mux;
  logic [DATA_W-1:0] r_readdata;

  assign w_ch    = 8'(address >> 3);
  assign w_reg   = address[2:0];
  assign w_ch_ok = (w_ch < 8'(NUM_CH));
  assign w_wr    = chipselect && !write_n && w_ch_ok;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    nes_timer_channel #(
      .CNT_W        (CNT_W),
      .PRESCALE_W   (PRESCALE_W),
      .RESET_PERIOD (RESET_PERIOD)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_wr      (w_wr && (w_ch == 8'(g))),
      .i_reg     (w_reg),
      .i_wdata   (writedata),
      .o_rdata_c (w_ch_rdata[g]),
      .o_irq_c   (irq_vec[g])
    );
  end

  // Unpopulated channel slots read as zero; PENDING mirrors irq_vec in every slot.
  always_comb begin
    w_rd_mux = '0;
    if (w_ch_ok) begin
      if (w_reg == REG_PENDING) begin
        w_rd_mux = DATA_W'(irq_vec);
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (w_ch == 8'(i)) begin
            w_rd_mux = w_ch_rdata[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rd_mux;
    end
  end

  assign readdata = r_readdata;
  assign irq      = |irq_vec;

endmodule

// File: tb/tb_nes_multi_timer.sv
// Bench for nes_multi_timer (3 channels, 24-bit counters): register table plus
// timed sequences; reads are scored against a queue of expected readdata.
module tb_nes_multi_timer;

  logic        clk;
  logic        reset_n;
  logic [4:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;
  logic [2:0]  irq_vec;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  typedef struct {
    string       name;
    logic [15:0] exp;
    int          due;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    bit          is_wr;
    logic [4:0]  addr;
    logic [15:0] data;
    string       name;
  } vec_t;
  vec_t vecs[$];

  nes_multi_timer #(
    .NUM_CH       (3),
    .CNT_W        (24),
    .PRESCALE_W   (8),
    .RESET_PERIOD (32'h1869F)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .irq_vec    (irq_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endfunction

  // Each read result lands in readdata one edge after the address is presented.
  always @(negedge clk) begin
    sb_t e;
    while (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check(e.name, 32'(readdata), 32'(e.exp));
    end
  end

  function automatic vec_t mk(input bit w, input logic [4:0] a, input logic [15:0] d, input string nm);
    vec_t v;
    v.is_wr = w; v.addr = a; v.data = d; v.name = nm;
    return v;
  endfunction

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [15:0] exp, input string nm);
    sb_t e;
    address = a; chipselect = 1'b1; write_n = 1'b1;
    e.name = nm; e.exp = exp; e.due = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    chipselect = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;

    vecs.push_back(mk(0, 5'd2,  16'h869F, "rst_ch0_period_l"));
    vecs.push_back(mk(0, 5'd3,  16'h0001, "rst_ch0_period_h"));
    vecs.push_back(mk(0, 5'd0,  16'h0000, "rst_ch0_status"));
    vecs.push_back(mk(0, 5'd1,  16'h0000, "rst_ch0_control"));
    vecs.push_back(mk(0, 5'd6,  16'h0000, "rst_ch0_prescale"));
    vecs.push_back(mk(0, 5'd4,  16'h0000, "rst_ch0_snap_l"));
    vecs.push_back(mk(0, 5'd10, 16'h869F, "rst_ch1_period_l"));
    vecs.push_back(mk(0, 5'd19, 16'h0001, "rst_ch2_period_h"));
    vecs.push_back(mk(0, 5'd7,  16'h0000, "rst_pending"));
    vecs.push_back(mk(0, 5'd24, 16'h0000, "ch3_status_zero"));
    vecs.push_back(mk(0, 5'd26, 16'h0000, "ch3_period_l_zero"));
    vecs.push_back(mk(1, 5'd6,  16'h12AB, ""));
    vecs.push_back(mk(0, 5'd6,  16'h00AB, "prescale_trunc"));
    vecs.push_back(mk(1, 5'd3,  16'hFFFF, ""));
    vecs.push_back(mk(0, 5'd3,  16'h00FF, "period_h_trunc"));
    vecs.push_back(mk(1, 5'd26, 16'h1234, ""));
    vecs.push_back(mk(0, 5'd26, 16'h0000, "ch3_write_ignored"));
    vecs.push_back(mk(0, 5'd2,  16'h869F, "ch0_untouched_by_ch3"));
    vecs.push_back(mk(1, 5'd1,  16'h000B, ""));
    vecs.push_back(mk(0, 5'd1,  16'h000B, "control_readback"));
    vecs.push_back(mk(0, 5'd0,  16'h0000, "stop_only_status"));
    vecs.push_back(mk(1, 5'd1,  16'h0000, ""));

    repeat (3) @(negedge clk);
    check("rst_readdata", 32'(readdata), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_irq_vec", 32'(irq_vec), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      if (vecs[i].is_wr) wr(vecs[i].addr, vecs[i].data);
      else rd(vecs[i].addr, vecs[i].data, vecs[i].name);
    end

    // ch1 continuous, period 9, prescale 0: timeout every 10 clocks
    wr(5'd10, 16'd9);
    wr(5'd11, 16'd0);
    wr(5'd9, 16'h0007);
    check("ch1_irq_start", 32'(irq), 32'h0);
    cycles(9);
    check("ch1_irq_before_to", 32'(irq), 32'h0);
    cycles(1);
    check("ch1_irq_first_to", 32'(irq), 32'h1);
    check("ch1_irq_vec", 32'(irq_vec), 32'h2);
    wr(5'd8, 16'h0000);
    check("ch1_irq_cleared", 32'(irq), 32'h0);
    cycles(8);
    check("ch1_irq_before_to2", 32'(irq), 32'h0);
    cycles(1);
    check("ch1_irq_second_to", 32'(irq), 32'h1);
    wr(5'd9, 16'h0008);
    check("ch1_irq_ito_off", 32'(irq), 32'h0);
    rd(5'd8, 16'h0001, "ch1_status_stopped");

    // ch2 one-shot, period 4, prescale 3: single timeout 20 clocks after START
    wr(5'd18, 16'd4);
    wr(5'd19, 16'd0);
    wr(5'd22, 16'd3);
    wr(5'd17, 16'h0004);
    cycles(19);
    rd(5'd16, 16'h0002, "ch2_running_pre_to");
    rd(5'd16, 16'h0001, "ch2_oneshot_done");
    wr(5'd20, 16'h0000);
    rd(5'd20, 16'h0004, "ch2_counter_reloaded");
    cycles(10);
    rd(5'd16, 16'h0001, "ch2_no_second_to");

    // STATUS write on the exact timeout edge must not lose the timeout
    wr(5'd16, 16'h0000);
    wr(5'd17, 16'h0007);
    cycles(19);
    check("ch2_irq_pre_to", 32'(irq), 32'h0);
    wr(5'd16, 16'h0000);
    check("ch2_to_survives_clear", 32'(irq), 32'h1);
    check("ch2_irq_vec", 32'(irq_vec), 32'h4);
    wr(5'd17, 16'h0009);
    check("ch2_irq_held_stopped", 32'(irq), 32'h1);
    rd(5'd7,  16'h0004, "pending_ch0");
    rd(5'd15, 16'h0004, "pending_ch1");
    rd(5'd23, 16'h0004, "pending_ch2");
    rd(5'd31, 16'h0000, "pending_ch3_zero");
    wr(5'd17, 16'h0000);
    check("ch2_irq_ito_cleared", 32'(irq), 32'h0);
    rd(5'd16, 16'h0001, "ch2_to_kept");
    wr(5'd16, 16'h0000);

    // START|STOP together: START wins
    wr(5'd9, 16'h000C);
    rd(5'd8, 16'h0003, "ch1_start_stop_run");
    rd(5'd9, 16'h000C, "ch1_control_strobes");
    wr(5'd9, 16'h0008);
    wr(5'd8, 16'h0000);

    // ch0: forced reload coincident with START, then PERIOD_L write while running
    wr(5'd6, 16'h0000);
    wr(5'd3, 16'h0000);
    wr(5'd1, 16'h0006);
    wr(5'd4, 16'h0000);
    rd(5'd4, 16'h869F, "ch0_snap_fresh_load");
    rd(5'd0, 16'h0002, "ch0_running");
    wr(5'd2, 16'd100);
    rd(5'd0, 16'h0002, "ch0_run_before_reload");
    rd(5'd0, 16'h0000, "ch0_stopped_by_reload");
    wr(5'd5, 16'h0000);
    rd(5'd4, 16'h0064, "ch0_snap_l_100");
    rd(5'd5, 16'h0000, "ch0_snap_h_0");
    rd(5'd2, 16'h0064, "ch0_period_l_100");

    // reset while ch1 is counting
    wr(5'd9, 16'h0007);
    cycles(3);
    rd(5'd2, 16'h0064, "pre_reset_read");
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_readdata", 32'(readdata), 32'h0);
    check("midrst_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;
    rd(5'd8,  16'h0000, "midrst_ch1_status");
    rd(5'd9,  16'h0000, "midrst_ch1_control");
    rd(5'd10, 16'h869F, "midrst_ch1_period_l");
    rd(5'd2,  16'h869F, "midrst_ch0_period_l");

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
